wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage of the RV32I core. It sits directly upstream of the register file and drives that file's
//  write port (we, rs3, wrs3). Accepts one retiring instruction per cycle via a valid/ready handshake and
//  selects the result (ALU, PC+4 or load). For loads it waits for the data-memory response, then aligns and
//  sign/zero-extends the data. Flags misaligned/illegal loads and memory timeouts; counts retired instructions.
// PARAMETERS
//  LOAD_TIMEOUT  255  cycles in WAIT_LOAD without mem_rvalid before load_fault; legal range 1..65535
// PORTS
//  clk            in   1   core clock; all state on rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  in_valid       in   1   upstream holds a retiring instruction
//  in_ready       out  1   stage can accept; ==1 only in IDLE
//  in_rd          in   5   destination register
//  in_wb_sel      in   2   00 ALU, 01 LOAD, 10 PC+4, 11 no write (store/branch)
//  in_funct3      in   3   load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  in_alu         in   32  ALU result; also load byte address (bits [1:0] used for alignment)
//  in_pc4         in   32  PC+4 for JAL/JALR
//  mem_rvalid     in   1   load data valid this cycle
//  mem_rdata      in   32  raw aligned word from data memory
//  we             out  1   register-file write enable (registered)
//  rs3            out  5   register-file write index (registered)
//  wrs3           out  32  register-file write data (registered)
//  misalign_fault out  1   1-cycle pulse: misaligned or illegal-funct3 load
//  load_fault     out  1   1-cycle pulse: load timeout
//  retired        out  32  count of instructions completed without a fault
// BEHAVIOUR
//  Reset: state IDLE; we=0, rs3=0, wrs3=0, faults=0, retired=0, timeout counter=0. A reset during WAIT_LOAD abandons the
//   load; a late mem_rvalid after reset is ignored.
//  Handshake: the stage accepts when in_valid & in_ready. in_ready = (state==IDLE), a combinational decode of the state register.
//  States: IDLE, WAIT_LOAD.
//  IDLE, accept, wb_sel 00/10/11: next edge we=(wb_sel!=11)&(rd!=0), rs3=rd, wrs3=ALU/PC4. retired+1.
//   Latency 1; back-to-back accepts every cycle.
//  IDLE, accept, wb_sel 01 with misaligned address (LH/LHU addr[0]=1, LW addr[1:0]!=0) or funct3 011/110/111:
//   next edge misalign_fault=1, we=0, stay IDLE, retired unchanged.
//  IDLE, accept, legal load: latch rd, funct3, addr[1:0]; we=0; counter cleared; go WAIT_LOAD.
//  WAIT_LOAD, mem_rvalid: next edge we=(rd!=0), rs3=rd, wrs3=aligned data, retired+1, go IDLE.
//   Upstream is accepted no earlier than the following cycle.
//  WAIT_LOAD, no rvalid: counter+1. When the counter reaches LOAD_TIMEOUT-1 without rvalid: next edge load_fault=1,
//   we=0, go IDLE. If rvalid arrives on that same cycle, rvalid wins (normal completion, no fault).
//  mem_rvalid in IDLE: ignored.
//  Align: byte = rdata[8*addr +: 8], half = rdata[16*addr[1] +: 16]. LB/LH sign-extend; LBU/LHU zero-extend.
//  we, misalign_fault and load_fault are 1-cycle pulses; rs3/wrs3 hold their last value when we=0.
//  retired wraps 0xFFFFFFFF -> 0. rd==0 counts as retired but never asserts we.
// STRUCTURE
//  Shared package wb_pkg holds: WB_ALU/WB_LOAD/WB_PC4/WB_NONE, F3_LB..F3_LHU, the state encoding, and the misalign predicate.
//  One sub-module, load_align (combinational: rdata, addr[1:0], funct3 -> 32-bit result), reused later by the LSU.
//  The top level holds the FSM, timeout counter, output registers and retire counter.
// TESTING
//  ALU: accept rd=5, sel=00, alu=0x1234 -> next cycle we=1, rs3=5, wrs3=0x1234, retired=1; three back-to-back ops,
//   all in consecutive cycles.
//  LB sign: addr=0x...3, rdata=0x80FF_0000, rvalid 2 cycles later -> wrs3=0xFFFFFF80; LBU same -> 0x00000080;
//   in_ready=0 throughout the wait.
//  LH addr=0x...1 -> misalign_fault pulse, we=0, retired unchanged; funct3=011 -> same result.
//  Timeout: LOAD_TIMEOUT=4, no rvalid -> load_fault asserted 4 cycles after acceptance, then IDLE;
//   rvalid on the 4th wait cycle -> normal write, no fault.
//  rd=0 with sel=00 or a load -> we stays 0, retired increments; sel=11 -> we=0, retired increments.
//  reset_n low mid-WAIT_LOAD, then rvalid after release -> all outputs 0, no write, state IDLE.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: result selects, load funct3 codes,
// FSM state encoding and the load legality predicate.
package wb_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_NONE = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } wb_state_t;

    // True when a load cannot be issued: misaligned address or unknown funct3.
    function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3)
            F3_LB, F3_LBU: return 1'b0;
            F3_LH, F3_LHU: return addr[0];
            F3_LW:         return addr != 2'b00;
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a raw memory word and sign- or
// zero-extends it according to the load funct3.
module load_align
    import wb_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign byte_val = rdata[{addr, 3'b000} +: 8];
    assign half_val = rdata[{addr[1], 4'b0000} +: 16];

    // NOTE: every path assigns result (default included), so no latch is inferred.
    always_comb begin
        case (funct3)
            F3_LB:   result = {{24{byte_val[7]}}, byte_val};
            F3_LH:   result = {{16{half_val[15]}}, half_val};
            F3_LBU:  result = {24'h0, byte_val};
            F3_LHU:  result = {16'h0, half_val};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: selects the retiring result, waits for load data with a
// timeout, and drives the registered register-file write port and retire counter.
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_wb_sel,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_pc4,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        we,
    output logic [4:0]  rs3,
    output logic [31:0] wrs3,
    output logic        misalign_fault,
    output logic        load_fault,
    output logic [31:0] retired
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(LOAD_TIMEOUT - 1);

    wb_state_t   state, next_state;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr;
    logic [15:0] timeout_cnt;
    logic [31:0] load_data;

    logic        accept, is_load, bad_load, start_load, timed_out;
    logic        we_d, misalign_d, load_fault_d, retire_inc;
    logic [4:0]  rs3_d;
    logic [31:0] wrs3_d;

    assign in_ready   = (state == S_IDLE);
    assign accept     = in_valid & in_ready;
    assign is_load    = (in_wb_sel == WB_LOAD);
    assign bad_load   = load_misaligned(in_funct3, in_alu[1:0]);
    assign start_load = accept & is_load & ~bad_load;
    assign timed_out  = (timeout_cnt == TIMEOUT_LAST);

    load_align u_load_align (
        .rdata  (mem_rdata),
        .addr   (ld_addr),
        .funct3 (ld_funct3),
        .result (load_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (start_load) next_state = S_WAIT_LOAD;
            S_WAIT_LOAD: if (mem_rvalid || timed_out) next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // Next values of the write port; rs3/wrs3 only move when a write happens.
    always_comb begin
        we_d         = 1'b0;
        rs3_d        = rs3;
        wrs3_d       = wrs3;
        misalign_d   = 1'b0;
        load_fault_d = 1'b0;
        retire_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && is_load) begin
                    misalign_d = bad_load;
                end else if (accept) begin
                    we_d       = (in_wb_sel != WB_NONE) && (in_rd != 5'd0);
                    retire_inc = 1'b1;
                    if (we_d) begin
                        rs3_d  = in_rd;
                        wrs3_d = (in_wb_sel == WB_PC4) ? in_pc4 : in_alu;
                    end
                end
            end
            S_WAIT_LOAD: begin
                if (mem_rvalid) begin
                    we_d       = (ld_rd != 5'd0);
                    retire_inc = 1'b1;
                    if (we_d) begin
                        rs3_d  = ld_rd;
                        wrs3_d = load_data;
                    end
                end else if (timed_out) begin
                    load_fault_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we             <= 1'b0;
            rs3            <= 5'd0;
            wrs3           <= 32'd0;
            misalign_fault <= 1'b0;
            load_fault     <= 1'b0;
            retired        <= 32'd0;
            ld_rd          <= 5'd0;
            ld_funct3      <= 3'd0;
            ld_addr        <= 2'd0;
            timeout_cnt    <= 16'd0;
        end else begin
            we             <= we_d;
            rs3            <= rs3_d;
            wrs3           <= wrs3_d;
            misalign_fault <= misalign_d;
            load_fault     <= load_fault_d;
            retired        <= retired + {31'd0, retire_inc};
            if (start_load) begin
                ld_rd       <= in_rd;
                ld_funct3   <= in_funct3;
                ld_addr     <= in_alu[1:0];
                timeout_cnt <= 16'd0;
            end else if (state == S_WAIT_LOAD && !mem_rvalid && !timed_out) begin
                timeout_cnt <= timeout_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage with a short load timeout.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu;
    logic [31:0] in_pc4;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        we;
    logic [4:0]  rs3;
    logic [31:0] wrs3;
    logic        misalign_fault;
    logic        load_fault;
    logic [31:0] retired;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_retired = 0;

    always #5 clk = ~clk;

    wb_stage #(.LOAD_TIMEOUT(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd          (in_rd),
        .in_wb_sel      (in_wb_sel),
        .in_funct3      (in_funct3),
        .in_alu         (in_alu),
        .in_pc4         (in_pc4),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .we             (we),
        .rs3            (rs3),
        .wrs3           (wrs3),
        .misalign_fault (misalign_fault),
        .load_fault     (load_fault),
        .retired        (retired)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one non-load op, clocks it in and checks the write port. in_valid stays high.
    task automatic do_op(input string tag, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc4);
        logic exp_we;
        in_valid = 1'b1; in_rd = rd; in_wb_sel = sel; in_funct3 = 3'd0;
        in_alu = alu; in_pc4 = pc4;
        tick();
        exp_we = (sel != 2'b11) && (rd != 5'd0);
        exp_retired++;
        check({tag, "_we"}, 32'(we), 32'(exp_we));
        if (exp_we) begin
            check({tag, "_rs3"}, 32'(rs3), 32'(rd));
            check({tag, "_wrs3"}, wrs3, (sel == 2'b10) ? pc4 : alu);
        end
        check({tag, "_retired"}, retired, exp_retired);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Issues a legal load, holds rvalid low for 'waits' wait cycles, then returns data.
    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input int waits, input logic [31:0] exp_data);
        in_valid = 1'b1; in_rd = rd; in_wb_sel = 2'b01; in_funct3 = f3; in_alu = addr;
        tick();
        in_valid = 1'b0;
        check({tag, "_acc_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_acc_we"}, 32'(we), 32'd0);
        mem_rdata = rdata;
        for (int i = 0; i < waits; i++) begin
            tick();
            check({tag, "_wait_ready"}, 32'(in_ready), 32'd0);
        end
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        exp_retired++;
        check({tag, "_we"}, 32'(we), 32'(rd != 5'd0));
        if (rd != 5'd0) begin
            check({tag, "_rs3"}, 32'(rs3), 32'(rd));
            check({tag, "_wrs3"}, wrs3, exp_data);
        end
        check({tag, "_retired"}, retired, exp_retired);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_lfault"}, 32'(load_fault), 32'd0);
    endtask

    // Presents an illegal load and checks the one-cycle misalign pulse.
    task automatic do_bad_load(input string tag, input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] held;
        held = wrs3;
        in_valid = 1'b1; in_rd = 5'd12; in_wb_sel = 2'b01; in_funct3 = f3; in_alu = addr;
        tick();
        in_valid = 1'b0;
        check({tag, "_mfault"}, 32'(misalign_fault), 32'd1);
        check({tag, "_we"}, 32'(we), 32'd0);
        check({tag, "_wrs3_hold"}, wrs3, held);
        check({tag, "_retired"}, retired, exp_retired);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        tick();
        check({tag, "_mfault_pulse"}, 32'(misalign_fault), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_wb_sel = '0; in_funct3 = '0;
        in_alu = '0; in_pc4 = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) tick();
        check("rst_we", 32'(we), 32'd0);
        check("rst_rs3", 32'(rs3), 32'd0);
        check("rst_wrs3", wrs3, 32'd0);
        check("rst_faults", 32'({misalign_fault, load_fault}), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        tick();

        // ALU result followed by three back-to-back ops
        do_op("alu0", 5'd5, 2'b00, 32'h0000_1234, 32'h0);
        do_op("alu1", 5'd1, 2'b00, 32'h0000_0011, 32'h0);
        do_op("pc4",  5'd2, 2'b10, 32'hFFFF_FFFF, 32'h0000_0104);
        do_op("alu3", 5'd3, 2'b00, 32'h0000_0033, 32'h0);
        in_valid = 1'b0;
        tick();
        check("idle_we_pulse", 32'(we), 32'd0);
        check("idle_rs3_hold", 32'(rs3), 32'd3);
        check("idle_wrs3_hold", wrs3, 32'h0000_0033);
        check("idle_retired", retired, exp_retired);

        // Loads with alignment and extension
        do_load("lb",  5'd7,  3'b000, 32'h0000_1003, 32'h80FF_0000, 1, 32'hFFFF_FF80);
        do_load("lbu", 5'd8,  3'b100, 32'h0000_1003, 32'h80FF_0000, 1, 32'h0000_0080);
        do_load("lh",  5'd9,  3'b001, 32'h0000_2002, 32'h80FF_0000, 0, 32'hFFFF_80FF);
        do_load("lhu", 5'd10, 3'b101, 32'h0000_2000, 32'h1234_8765, 2, 32'h0000_8765);
        do_load("lw",  5'd11, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
        do_load("lb1", 5'd13, 3'b000, 32'h0000_3001, 32'h0000_7F00, 0, 32'h0000_007F);

        // Illegal loads
        do_bad_load("mis_lh", 3'b001, 32'h0000_4001);
        do_bad_load("mis_lw", 3'b010, 32'h0000_4002);
        do_bad_load("ill_f3", 3'b011, 32'h0000_4000);

        // Timeout: no rvalid ever
        in_valid = 1'b1; in_rd = 5'd14; in_wb_sel = 2'b01; in_funct3 = 3'b010; in_alu = 32'h0;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("to_wait_lfault", 32'(load_fault), 32'd0);
            check("to_wait_ready", 32'(in_ready), 32'd0);
        end
        tick();
        check("to_lfault", 32'(load_fault), 32'd1);
        check("to_we", 32'(we), 32'd0);
        check("to_ready", 32'(in_ready), 32'd1);
        check("to_retired", retired, exp_retired);
        tick();
        check("to_lfault_pulse", 32'(load_fault), 32'd0);

        // rvalid on the last wait cycle wins over the timeout
        do_load("to_edge", 5'd15, 3'b010, 32'h0000_5000, 32'hCAFE_F00D, 3, 32'hCAFE_F00D);

        // rd==0 and no-write ops still retire
        do_op("rd0_alu", 5'd0, 2'b00, 32'h0000_0055, 32'h0);
        do_op("sel11",   5'd4, 2'b11, 32'h0000_0066, 32'h0);
        in_valid = 1'b0;
        do_load("rd0_ld", 5'd0, 3'b010, 32'h0000_6000, 32'h1111_1111, 0, 32'h0);

        // Reset in the middle of a load, then a late rvalid
        in_valid = 1'b1; in_rd = 5'd16; in_wb_sel = 2'b01; in_funct3 = 3'b010; in_alu = 32'h0;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        exp_retired = 0;
        check("mr_ready", 32'(in_ready), 32'd1);
        check("mr_retired", retired, 32'd0);
        check("mr_wrs3", wrs3, 32'd0);
        mem_rdata = 32'hBAD0_BAD0;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check("late_we", 32'(we), 32'd0);
        check("late_rs3", 32'(rs3), 32'd0);
        check("late_wrs3", wrs3, 32'd0);
        check("late_faults", 32'({misalign_fault, load_fault}), 32'd0);
        check("late_retired", retired, 32'd0);
        check("late_ready", 32'(in_ready), 32'd1);

        do_op("post_rst", 5'd6, 2'b00, 32'h0000_ABCD, 32'h0);
        in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
